// File: rtl/alu_mdu_pkg.sv
// Shared encodings for the ALU/MDU slice: ALU op select, MDU op select and
// MDU controller states.
package alu_mdu_pkg;

  typedef enum logic [3:0] {
    ALU_ADDU  = 4'd0,
    ALU_SUBU  = 4'd1,
    ALU_OR    = 4'd2,
    ALU_AND   = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_LUI   = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_SLTU  = 4'd8,
    ALU_MOVZ  = 4'd9,
    ALU_ROTRV = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU; undefined op selects produce zero.
module alu_core
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluctr,
  output logic [WIDTH-1:0] aluout
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]      sh;
  logic [2*WIDTH-1:0] rot;

  // Shifting a doubled copy right gives the rotation in the low half; sh=0 is b.
  assign sh  = a[SW-1:0];
  assign rot = {b, b} >> sh;

  always_comb begin
    aluout = '0;
    case (aluctr)
      ALU_ADDU:  aluout = a + b;
      ALU_SUBU:  aluout = a - b;
      ALU_OR:    aluout = a | b;
      ALU_AND:   aluout = a & b;
      ALU_XOR:   aluout = a ^ b;
      ALU_NOR:   aluout = ~(a | b);
      ALU_LUI:   aluout = b << (WIDTH / 2);
      ALU_SLT:   aluout = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  aluout = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_MOVZ:  aluout = a;
      ALU_ROTRV: aluout = rot[WIDTH-1:0];
      default:   aluout = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// ALU plus a multi-cycle multiply/divide unit with HI/LO registers.
// md_start is a one-cycle qualifier for md_op; it is only honoured while idle.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluctr,
  output logic [WIDTH-1:0] aluout,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output md_state_e        state
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]   op_a, op_b;
  logic               op_signed;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               div_zero, div_ovf;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a      (a),
    .b      (b),
    .aluctr (aluctr),
    .aluout (aluout)
  );

  // One 2W-bit multiplier serves both flavours: sign-extend only for mult.
  assign ext_a = {{WIDTH{op_signed & op_a[WIDTH-1]}}, op_a};
  assign ext_b = {{WIDTH{op_signed & op_b[WIDTH-1]}}, op_b};
  assign prod  = ext_a * ext_b;

  assign div_zero = (op_b == '0);
  assign div_ovf  = op_signed && (op_a == MIN_VAL) && (op_b == '1);

  always_comb begin
    quo = '0;
    rem = '0;
    if (div_zero) begin
      quo = '0;
      rem = '0;
    end else if (div_ovf) begin
      quo = MIN_VAL;
      rem = '0;
    end else if (op_signed) begin
      quo = WIDTH'($signed(op_a) / $signed(op_b));
      rem = WIDTH'($signed(op_a) % $signed(op_b));
    end else begin
      quo = op_a / op_b;
      rem = op_a % op_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md_start) begin
            case (md_op_e'(md_op))
              MD_MULT, MD_MULTU: begin
                op_a      <= a;
                op_b      <= b;
                op_signed <= (md_op == MD_MULT);
                cnt       <= CW'(MUL_LAT);
                busy      <= 1'b1;
                state     <= ST_MUL;
              end
              MD_DIV, MD_DIVU: begin
                op_a      <= a;
                op_b      <= b;
                op_signed <= (md_op == MD_DIV);
                cnt       <= CW'(DIV_LAT);
                busy      <= 1'b1;
                state     <= ST_DIV;
              end
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cnt == CW'(1)) begin
            {hi, lo} <= prod;
            cnt      <= '0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DIV: begin
          if (cnt == CW'(1)) begin
            // A zero divisor still costs the full latency but leaves HI/LO alone.
            if (!div_zero) begin
              hi <= rem;
              lo <= quo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed and lightly randomised bench for alu_mdu; MDU results go through an
// expected queue that is popped when busy falls.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a_i, b_i, aluout, hi, lo;
  logic [3:0]   aluctr;
  logic [2:0]   md_op;
  logic         md_start, busy;
  md_state_e    state;

  logic [2*W-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a_i),
    .b        (b_i),
    .aluctr   (aluctr),
    .aluout   (aluout),
    .md_op    (md_op),
    .md_start (md_start),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .state    (state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] ctr,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] exp);
    aluctr = ctr;
    a_i    = av;
    b_i    = bv;
    #1;
    chk(tag, {32'b0, aluout}, {32'b0, exp});
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic md_issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    md_op    = op;
    a_i      = av;
    b_i      = bv;
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    md_op    = MD_NONE;
  endtask

  // Counts busy cycles, optionally injects a start at busy cycle inject_at,
  // then compares HI/LO against the head of the expected queue.
  task automatic md_wait(input string tag, input int lat, input int inject_at);
    int             n = 0;
    logic           held_ok = 1'b1;
    logic [2*W-1:0] held;
    logic [2*W-1:0] e;
    held = {hi, lo};
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == inject_at) begin
        md_op    = MD_MULT;
        a_i      = 32'd5;
        b_i      = 32'd5;
        md_start = 1'b1;
      end else begin
        md_start = 1'b0;
        md_op    = MD_NONE;
      end
      @(negedge clk);
      if (busy === 1'b1 && {hi, lo} !== held) held_ok = 1'b0;
    end
    md_start = 1'b0;
    md_op    = MD_NONE;
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_hold"}, {63'b0, held_ok}, 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk({tag, "_hilo"}, {hi, lo}, e);
    chk({tag, "_state"}, 64'(state), 64'(ST_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, rr;
    longint       sa, sb, sp;

    reset    = 1'b0;
    md_start = 1'b0;
    md_op    = MD_NONE;
    a_i      = '0;
    b_i      = '0;
    aluctr   = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_hi",    64'(hi),    64'd0);
    chk("rst_lo",    64'(lo),    64'd0);
    chk("rst_state", 64'(state), 64'(ST_IDLE));

    // First start lands on the first edge after release.
    reset = 1'b1;
    md_issue(MD_MTHI, 32'h55, 32'h0);
    chk("mthi_hi",   64'(hi),   64'h55);
    chk("mthi_busy", 64'(busy), 64'd0);
    md_issue(MD_MTLO, 32'hAA, 32'h0);
    chk("mtlo_lo",   64'(lo),   64'hAA);
    chk("mtlo_busy", 64'(busy), 64'd0);

    md_issue(MD_NONE, 32'h1234, 32'h5678);
    md_issue(3'd7, 32'h1234, 32'h5678);
    chk("none_hilo", {hi, lo}, {32'h55, 32'hAA});
    chk("none_busy", 64'(busy), 64'd0);

    exp_q.push_back({32'h55, 32'hAA});
    md_issue(MD_DIVU, 32'd123, 32'd0);
    md_wait("divz", 10, 0);

    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    md_issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    md_wait("mult", 5, 0);

    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    md_issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    md_wait("div_inj", 10, 3);
    @(negedge clk);
    chk("div_inj_norestart", 64'(busy), 64'd0);

    exp_q.push_back({32'h0, 32'h8000_0000});
    md_issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    md_wait("div_ovf", 10, 0);

    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    md_issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_wait("multu", 5, 0);

    exp_q.push_back({32'd2, 32'd14});
    md_issue(MD_DIVU, 32'd100, 32'd7);
    md_wait("divu", 10, 0);

    exp_q.push_back({32'd1, 32'hFFFF_FFFD});
    md_issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    md_wait("div_negb", 10, 0);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      sp = sa * sb;
      exp_q.push_back(sp);
      md_issue(MD_MULT, ra, rb);
      md_wait("rnd_mult", 5, 0);
      rb = $urandom_range(1, 1000);
      exp_q.push_back({ra % rb, ra / rb});
      md_issue(MD_DIVU, ra, rb);
      md_wait("rnd_divu", 10, 0);
    end

    // Reset during the second busy cycle aborts the multiply.
    md_issue(MD_MULT, 32'd9, 32'd9);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_busy",  64'(busy),  64'd0);
    chk("rstmid_hi",    64'(hi),    64'd0);
    chk("rstmid_lo",    64'(lo),    64'd0);
    chk("rstmid_state", 64'(state), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(64'd35);
    md_issue(MD_MULT, 32'd5, 32'd7);
    md_wait("post_rst_mult", 5, 0);
    chk("q_empty", 64'(exp_q.size()), 64'd0);

    alu_chk("rotrv4",   ALU_ROTRV, 32'd4,  32'h0000_00F1, 32'h1000_000F);
    alu_chk("rotrv0",   ALU_ROTRV, 32'd0,  32'h0000_00F1, 32'h0000_00F1);
    alu_chk("rotrv36",  ALU_ROTRV, 32'd36, 32'h0000_00F1, 32'h1000_000F);
    alu_chk("slt",      ALU_SLT,   32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_chk("sltu",     ALU_SLTU,  32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_chk("addu",     ALU_ADDU,  32'hFFFF_FFFF, 32'd2, 32'd1);
    alu_chk("subu",     ALU_SUBU,  32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_chk("or",       ALU_OR,    32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    alu_chk("and",      ALU_AND,   32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    alu_chk("xor",      ALU_XOR,   32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    alu_chk("nor",      ALU_NOR,   32'hF0F0_0000, 32'h0000_0F0F, 32'h0F0F_F0F0);
    alu_chk("lui",      ALU_LUI,   32'h0, 32'h0000_1234, 32'h1234_0000);
    alu_chk("movz",     ALU_MOVZ,  32'hDEAD_BEEF, 32'h1, 32'hDEAD_BEEF);
    alu_chk("undef11",  4'd11,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    alu_chk("undef15",  4'd15,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom_range(0, 31));
      rb = $urandom;
      rr = rb;
      for (int k = 0; k < int'(ra); k++) rr = {rr[0], rr[W-1:1]};
      alu_chk("rnd_rotrv", ALU_ROTRV, ra, rb, rr);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; SHALL be a power of two, at least 8.
REQ-002 Parameter MUL_LAT, default 5: busy cycles for mult/multu; SHALL be at least 1.
REQ-003 Parameter DIV_LAT, default 10: busy cycles for div/divu; SHALL be at least 1.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 a  in  WIDTH  operand A (rs).
REQ-008 b  in  WIDTH  operand B (rt or extended immediate).
REQ-009 aluctr  in  4  ALU operation select; encodings in head.v.
REQ-010 aluout  out  WIDTH  combinational ALU result.
REQ-011 md_op  in  3  MDU operation: none, mult, multu, div, divu, mthi, mtlo.
REQ-012 md_start  in  1  qualifies md_op for one cycle.
REQ-013 busy  out  1  MDU iteration in progress.
REQ-014 hi  out  WIDTH  HI register.
REQ-015 lo  out  WIDTH  LO register.

Function
REQ-016 aluout SHALL be purely combinational: addu A+B; subu A-B; or A|B; and A&B; xor A^B; nor ~(A|B).
REQ-017 Further aluout ops: lui B<<(WIDTH/2); slt signed A<B ? 1 : 0; sltu unsigned; movz passes A.
REQ-018 rotrv SHALL rotate B right by A[log2(WIDTH)-1:0]; amount 0 SHALL return B unchanged.
REQ-019 Any undefined aluctr SHALL give aluout = 0.
REQ-020 MDU FSM states SHALL be IDLE, MUL and DIV; reset state is IDLE.
REQ-021 md_start=1 in IDLE with mult/multu SHALL latch a and b, enter MUL, and raise busy at the next edge.
REQ-022 md_start=1 in IDLE with div/divu SHALL latch a and b, enter DIV, and raise busy at the next edge.
REQ-023 busy SHALL stay high exactly MUL_LAT or DIV_LAT cycles; a down-counter of width clog2(max latency)+1 SHALL count them.
REQ-024 On the last busy cycle's edge, hi/lo SHALL update, busy SHALL fall, and the FSM SHALL return to IDLE.
REQ-025 mult/multu: {hi,lo} SHALL be the 2*WIDTH signed or unsigned product.
REQ-026 div/divu: lo SHALL be the quotient, truncated toward zero; hi SHALL be the remainder, taking the sign of the dividend.
REQ-027 Divide by zero SHALL leave hi/lo unchanged, with busy still held for DIV_LAT cycles.
REQ-028 Signed MIN / -1 SHALL give lo=MIN and hi=0.
REQ-029 mthi/mtlo with md_start in IDLE SHALL write a to hi or lo at the next edge; busy SHALL not assert.
REQ-030 md_start while busy SHALL be ignored entirely: no latch, no hi/lo write, no restart.
REQ-031 md_start with md_op=none SHALL have no effect.
REQ-032 hi/lo SHALL be readable every cycle; during busy they SHALL hold their previous values.

Reset
REQ-033 Reset low SHALL asynchronously force FSM=IDLE, busy=0, hi=0, lo=0, counter=0 and clear the latched operands.
REQ-034 Reset asserted mid-operation SHALL abort the operation; no partial result SHALL reach hi/lo.
REQ-035 The first md_start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-036 aluctr and md_op encodings and the FSM state constants SHALL live in the shared header head.v.
REQ-037 The combinational ALU SHALL be sub-module alu_core, parametrised by WIDTH; the MDU FSM, counter and HI/LO SHALL be in alu_mdu.

Verification
REQ-038 Rotrv: WIDTH=32, a=4, b=0x0000_00F1 gives aluout=0x1000_000F; a=0 gives 0x0000_00F1.
REQ-039 Slt/sltu: a=0xFFFF_FFFF, b=1 gives slt=1 and sltu=0.
REQ-040 Mult: a=-3, b=7, start gives busy for 5 cycles, then hi=0xFFFF_FFFF and lo=0xFFFF_FFEB.
REQ-041 Div: a=-7, b=2, start gives lo=-3 and hi=-1 after 10 busy cycles; a second start at busy cycle 3 is ignored.
REQ-042 Divide by zero: hi=0x55, lo=0xAA preset by mthi/mtlo, then divu by 0 gives busy 10 cycles and hi/lo unchanged.
REQ-043 Reset mid-mult: reset low at busy cycle 2 gives busy=0 and hi=lo=0 immediately, and a new mult after release is accepted.
